// File: rtl/snowv_aes_arb_if.sv
// Request/response bundle between two AES-round clients and the shared round arbiter.
// The arbiter takes the slave modport; a client (or a bench acting for both) takes the master modport.
interface snowv_aes_arb_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_data;
    logic [127:0] req0_key;

    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_data;
    logic [127:0] req1_key;

    logic         rsp0_valid;
    logic         rsp0_ready;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [127:0] rsp_data;
    logic         busy;

    modport slave (
        input  req0_valid, req0_data, req0_key,
        output req0_ready,
        input  req1_valid, req1_data, req1_key,
        output req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, busy,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_data, req0_key,
        input  req0_ready,
        output req1_valid, req1_data, req1_key,
        input  req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, busy,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/snowv_aes_arb.sv
// Round-robin arbiter sharing one combinational AES round between two clients,
// with a single registered response slot that also allows same-cycle drain and refill.
module snowv_aes_arb #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    snowv_aes_arb_if.slave  bus
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // State is column-major with byte 0 in the top bits: byte index = row + 4*column.
    function automatic logic [127:0] aes_round(input logic [127:0] state, input logic [127:0] key);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] mc;
        // NOTE: function locals are combinational temporaries, so blocking '=' is correct here;
        // only clocked state uses '<='.
        mc = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[state[127 - 8*i -: 8]];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c + 1];
            a2 = sr[4*c + 2];
            a3 = sr[4*c + 3];
            mc[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return mc ^ key;
    endfunction

    logic         slot_full;
    logic         slot_owner;
    logic [127:0] slot_data;
    logic         prio;

    logic         drain;
    logic         free;
    logic         grant_valid;
    logic         grant_id;
    logic [127:0] sel_data;
    logic [127:0] sel_key;
    logic [127:0] round_out;

    assign drain = slot_full & (slot_owner ? bus.rsp1_ready : bus.rsp0_ready);
    assign free  = !slot_full | drain;

    // Grant is suppressed during reset so nothing is accepted in the reset cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        grant_id    = 1'b0;
        grant_valid = free & !rst & (bus.req0_valid | bus.req1_valid);
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = prio;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign bus.req0_ready = grant_valid & !grant_id;
    assign bus.req1_ready = grant_valid &  grant_id;

    assign sel_data  = grant_id ? bus.req1_data : bus.req0_data;
    assign sel_key   = grant_id ? bus.req1_key  : bus.req0_key;
    assign round_out = aes_round(sel_data, sel_key);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full  <= 1'b0;
            slot_owner <= 1'b0;
            // NOTE: the result register is cleared too, because rsp_data must read zero after reset.
            slot_data  <= '0;
            prio       <= PRIO_INIT;
        end else if (grant_valid) begin
            slot_full  <= 1'b1;
            slot_owner <= grant_id;
            slot_data  <= round_out;
            prio       <= !grant_id;
        end else if (drain) begin
            slot_full  <= 1'b0;
        end
    end

    assign bus.rsp0_valid = slot_full & !slot_owner;
    assign bus.rsp1_valid = slot_full &  slot_owner;
    assign bus.rsp_data   = slot_data;
    assign bus.busy       = slot_full;

    // Interface invariants; ignored by synthesis.
    ready_onehot: assert property (@(posedge clk) disable iff (rst)
        !(bus.req0_ready && bus.req1_ready));
    rsp0_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.rsp0_valid && !bus.rsp0_ready) |=> (bus.rsp0_valid && $stable(bus.rsp_data)));
    rsp1_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.rsp1_valid && !bus.rsp1_ready) |=> (bus.rsp1_valid && $stable(bus.rsp_data)));

endmodule

// File: tb/tb_snowv_aes_arb.sv
// Directed bench for snowv_aes_arb: reset, AES round vectors, round-robin, back-pressure, reset mid-operation.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
module tb_snowv_aes_arb;

    localparam logic [127:0] ZERO   = 128'h0;
    localparam logic [127:0] ONES   = {16{8'hff}};
    localparam logic [127:0] R63    = {16{8'h63}};
    localparam logic [127:0] R9C    = {16{8'h9c}};
    localparam logic [127:0] D52    = {16{8'h52}};
    localparam logic [127:0] K0     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_D = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_K = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R = 128'ha49c7ff2689f352b6b5bea43026a5049;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    snowv_aes_arb_if bus ();

    snowv_aes_arb #(.PRIO_INIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = ZERO;
        bus.req0_key   = ZERO;
        bus.req1_data  = ZERO;
        bus.req1_key   = ZERO;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        cyc();
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got %b%b want 00", bus.req0_ready, bus.req1_ready);
        end
        cyc();
        idle_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_state got busy=%b v0=%b v1=%b want 000", bus.busy, bus.rsp0_valid, bus.rsp1_valid);
        end
        checks++;
        if (bus.rsp_data !== ZERO) begin
            errors++;
            $display("FAIL rst_data got %h want %h", bus.rsp_data, ZERO);
        end
    endtask

    task automatic test_zero_key();
        bus.req0_valid = 1'b1;
        bus.req0_data  = ZERO;
        bus.req0_key   = ZERO;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL zk_grant got %b%b want 10", bus.req0_ready, bus.req1_ready);
        end
        cyc();
        // Same cycle: drain the first result while a second request (all-ones key) is accepted.
        bus.req0_key   = ONES;
        bus.rsp0_ready = 1'b1;
        #1;
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp_data !== R63) begin
            errors++;
            $display("FAIL zk_rsp got v0=%b v1=%b %h want v0=1 v1=0 %h", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, R63);
        end
        checks++;
        if (bus.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL zk_passthru_ready got %b want 1", bus.req0_ready);
        end
        cyc();
        bus.req0_valid = 1'b0;
        bus.rsp0_ready = 1'b0;
        #1;
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== R9C) begin
            errors++;
            $display("FAIL ones_key_rsp got v0=%b %h want v0=1 %h", bus.rsp0_valid, bus.rsp_data, R9C);
        end
        bus.rsp0_ready = 1'b1;
        cyc();
        bus.rsp0_ready = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zk_drained got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_fips();
        bus.req1_valid = 1'b1;
        bus.req1_data  = FIPS_D;
        bus.req1_key   = FIPS_K;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL fips_grant got %b%b want 01", bus.req0_ready, bus.req1_ready);
        end
        cyc();
        bus.req1_valid = 1'b0;
        #1;
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp_data !== FIPS_R) begin
            errors++;
            $display("FAIL fips_rsp got v0=%b v1=%b %h want v0=0 v1=1 %h", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, FIPS_R);
        end
        bus.rsp1_ready = 1'b1;
        cyc();
        bus.rsp1_ready = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL fips_drained got busy=%b want 0", bus.busy);
        end
    endtask

    // Prio is 0 here (last accept went to requester 1), so grants run 0,1,0,1.
    task automatic test_round_robin();
        logic prev;
        logic exp_g;
        prev = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = ZERO;
        bus.req0_key   = ZERO;
        bus.req1_valid = 1'b1;
        bus.req1_data  = FIPS_D;
        bus.req1_key   = FIPS_K;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 1);
            #1;
            checks++;
            if (bus.req0_ready !== !exp_g || bus.req1_ready !== exp_g) begin
                errors++;
                $display("FAIL rr_grant%0d got %b%b want grant %0d", i, bus.req0_ready, bus.req1_ready, exp_g);
            end
            if (i > 0) begin
                checks++;
                if (bus.rsp0_valid !== !prev || bus.rsp1_valid !== prev || bus.rsp_data !== (prev ? FIPS_R : R63)) begin
                    errors++;
                    $display("FAIL rr_rsp%0d got v0=%b v1=%b %h want owner %0d", i, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, prev);
                end
            end
            prev = exp_g;
            cyc();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp_data !== FIPS_R) begin
            errors++;
            $display("FAIL rr_last got v1=%b %h want v1=1 %h", bus.rsp1_valid, bus.rsp_data, FIPS_R);
        end
        cyc();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_drained got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_back_pressure();
        // Data of all 0x52 bytes maps through the S-box to zero, so the round result equals the key.
        bus.req0_valid = 1'b1;
        bus.req0_data  = D52;
        bus.req0_key   = K0;
        cyc();
        bus.req0_data  = ZERO;
        bus.req0_key   = ZERO;
        bus.req1_valid = 1'b1;
        bus.req1_data  = FIPS_D;
        bus.req1_key   = FIPS_K;
        for (int i = 0; i < 5; i++) begin
            bus.rsp1_ready = (i >= 2);
            #1;
            checks++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.rsp0_valid !== 1'b1 || bus.rsp_data !== K0) begin
                errors++;
                $display("FAIL bp_hold%0d got r=%b%b v0=%b %h want r=00 v0=1 %h", i, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp_data, K0);
            end
            cyc();
        end
        bus.rsp1_ready = 1'b0;
        bus.rsp0_ready = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_grant got %b%b want 01", bus.req0_ready, bus.req1_ready);
        end
        cyc();
        bus.rsp0_ready = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp_data !== FIPS_R) begin
            errors++;
            $display("FAIL bp_new_rsp got v0=%b v1=%b %h want v0=0 v1=1 %h", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, FIPS_R);
        end
    endtask

    // Enters with the slot held by requester 1; refill it for requester 0 so prio becomes 1.
    task automatic test_reset_mid();
        bus.rsp1_ready = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_data  = D52;
        bus.req0_key   = K0;
        cyc();
        bus.rsp1_ready = 1'b0;
        bus.req0_data  = ZERO;
        bus.req0_key   = ZERO;
        bus.req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.rsp_data !== K0) begin
            errors++;
            $display("FAIL mid_rst_cycle got r=%b%b %h want r=00 %h", bus.req0_ready, bus.req1_ready, bus.rsp_data, K0);
        end
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_data !== ZERO || bus.rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_state got busy=%b v0=%b %h want busy=0 v0=0 %h", bus.busy, bus.rsp0_valid, bus.rsp_data, ZERO);
        end
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_prio got %b%b want 10", bus.req0_ready, bus.req1_ready);
        end
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== R63) begin
            errors++;
            $display("FAIL mid_rst_after got v0=%b %h want v0=1 %h", bus.rsp0_valid, bus.rsp_data, R63);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_zero_key();
        test_fips();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snowv_aes_arb.md
# snowv_aes_arb

Two-requester arbiter and sequencer that shares a single combinational AES round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey; byte 0 at bits [127:120]) between two 128-bit clients. Typical clients are the SNOW-V FSM update paths R2' = AES(R1) and R3' = AES(R2), or a FSM path and a test/AEAD client.

The block has three jobs:
- Arbitrate between the two clients with round-robin priority.
- Launch one round per accepted request.
- Hold each result in a single registered response slot until its owner takes it.

## Interface
**Parameters**
- PRIO_INIT, default 0: requester that holds priority after reset (0 or 1).

**Ports**
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_data  input  128  round input state, requester 0.
- req0_key  input  128  round key, requester 0.
- req1_valid, req1_ready, req1_data, req1_key: same as above, requester 1.
- rsp0_valid  output  1  result for requester 0 is held.
- rsp0_ready  input  1  requester 0 takes result.
- rsp1_valid  output  1  result for requester 1 is held.
- rsp1_ready  input  1  requester 1 takes result.
- rsp_data  output  128  held result, shared by both response ports.
- busy  output  1  response slot occupied.

## Operation
- **State**
  - slot_full: 1 bit.
  - slot_owner: 1 bit.
  - slot_data: 128 bits.
  - prio: 1 bit, round-robin pointer.
- **Drain.** drain = slot_full & ((slot_owner==0 & rsp0_ready) | (slot_owner==1 & rsp1_ready)).
- **Free.** free = !slot_full | drain. Pass-through is allowed, so a combinational path exists from rspN_ready to reqM_ready.
- **Grant** (combinational, only when free):
  - Only one request valid: that requester is granted.
  - Both valid: requester prio is granted.
  - Neither valid: no grant.
- **Ready.** reqN_ready = grant to N. reqN_ready never depends on reqN_ready of the other port.
- **Accept** (valid & ready):
  - slot_data <= AES_round(req_data, req_key) of the granted requester.
  - slot_owner <= granted id.
  - slot_full <= 1.
  - prio <= !granted id.
  - prio changes only on an accept.
- **Drain without accept:** slot_full <= 0. slot_data and slot_owner are held.
- **Response outputs:**
  - rsp0_valid = slot_full & slot_owner==0.
  - rsp1_valid = slot_full & slot_owner==1.
  - rsp_data = slot_data.
  - busy = slot_full.
- **Non-owner ready:** rspN_ready from the non-owner is ignored.
- **Stability:** while rspN_valid=1 and rspN_ready=0, rsp_data and the valids are held stable.
- **Request holding:** requesters must hold data and key stable while valid=1 and ready=0. The arbiter does not latch inputs before the grant.
- **Fairness:** with both requesters continuously valid and responses always ready, grants strictly alternate. Neither requester waits more than one accept.
- **Reset:** slot_full=0, slot_owner=0, slot_data=0, prio=PRIO_INIT. A pending response is discarded. Requests presented in the reset cycle are not accepted.

## Timing
- **Reset values:**
  - req0_ready = req1_ready = 0 while rst=1.
  - rsp0_valid = rsp1_valid = 0.
  - busy = 0.
  - rsp_data = 0.
- **Latency:** accept in cycle T gives rspN_valid=1 with the result in cycle T+1.
- **Throughput:** with an immediate drain, one accept per cycle, sustained from either or both requesters.
- **Back-pressure:** while the owner holds rsp ready low, both req_ready stay 0 (slot full, no drain).
- **Simultaneous drain and accept in one cycle:** the old result leaves, the new result appears next cycle, and valid stays 1 (the owner may change).
- **Critical path:** mux, then S-box, then MixColumns, then XOR, then register. No internal pipelining.

## Test plan
- **Zero-key round:** reset, then req0 data=0, key=0 -> next cycle rsp0_valid=1, rsp_data=0x6363…63 (16 bytes). With key=all-ones -> 0x9c9c…9c.
- **FIPS-197 App. B round 1:** req1 data=193de3bea0f4e22b9ac68d2ae9f84808, key=a0fafe1788542cb123a339392a6c7605 -> rsp1_valid, rsp_data=a49c7ff2689f352b6b5bea43026a5049; rsp0_valid stays 0.
- **Round-robin:** PRIO_INIT=0, both valid continuously, rsp ready always 1 -> grant sequence 0,1,0,1. One accept per cycle, results alternate owner with matching data.
- **Back-pressure:** slot held by requester 0 with rsp0_ready=0 for 5 cycles, both requesters valid -> no req_ready, rsp_data stable. Asserting rsp1_ready has no effect. rsp0_ready=1 -> same-cycle grant to prio, new result next cycle.
- **Reset mid-operation:** slot full and both requesters valid, assert rst one cycle -> next cycle busy=0, rsp_data=0, prio=PRIO_INIT, no accept during the rst cycle.
